game_tick_gen: RTL and testbench
================================

// Module: game_tick_gen
// PURPOSE
//   Consumer end of the game-step signal. Runs in the 25 MHz pixel-clock domain and turns either
//   VGA frame sync (auto mode) or a debounced push-button press (manual mode) into a clean
//   one-cycle game-logic enable. tick_out gates all game-state registers; nothing downstream
//   is clocked by a derived clock.
// PARAMETERS
//   DEBOUNCE_CYCLES  250000  consecutive stable cycles before the key level is accepted (10 ms @ 25 MHz)
//   CNT_W            18      debounce counter width; must hold DEBOUNCE_CYCLES
//   FRAME_DIV        1       auto mode: one tick per FRAME_DIV frame-sync rising edges (1..15)
//   TICK_W           16      width of tick_count_out
// PORTS
//   clk              in   1       25 MHz pixel clock; only clock
//   rst              in   1       synchronous, active-high reset
//   sw_mode_in       in   1       SW[1], async: 0 = auto (frame-driven), 1 = manual step
//   key_step_n_in    in   1       KEY, async, active-low, bouncy
//   frame_sync_in    in   1       level from VGA timing, already in clk domain; high during vblank
//   tick_out         out  1       one-cycle game-step enable
//   tick_count_out   out  TICK_W  ticks issued since reset; wraps
//   manual_mode_out  out  1       registered, synchronized mode actually in effect
// BEHAVIOUR
//   Reset: tick_out=0, tick_count_out=0, manual_mode_out=0, debounced key=1 (released),
//          frame divider=0, all synchronizer flops=0 except key sync=1.
//   Sync: sw_mode_in and key_step_n_in each pass through a 2-FF synchronizer.
//   Debounce: counter clears whenever synced key equals debounced level; otherwise increments.
//          Reaching DEBOUNCE_CYCLES-1 copies synced level into debounced level and clears counter.
//          Press event = debounced 1->0 transition (one cycle). Debouncer runs in both modes.
//   Frame edge: frame_sync_in delayed one flop; edge = in & ~dly.
//   Mode FSM: AUTO, MANUAL. AUTO->MANUAL when synced sw=1; MANUAL->AUTO when synced sw=0.
//          In the transition cycle, clear the frame divider and suppress any tick.
//   AUTO: on frame edge, divider==FRAME_DIV-1 -> tick next cycle, divider=0; else divider+1.
//          Press events are ignored.
//   MANUAL: press event -> tick next cycle. Frame edges are ignored; divider holds 0.
//   Latency: frame edge -> tick_out is 1 cycle. Key settles low -> tick_out is
//          2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//   tick_out is high for exactly 1 cycle. Ticks are never back-to-back in MANUAL.
//   tick_count_out increments the same cycle tick_out=1; 2^TICK_W-1 -> 0 wraps silently.
//   Mid-operation rst: all state returns to reset values next cycle. A key held through
//          reset produces no tick until it is released and pressed again.
//   A key held low across AUTO->MANUAL produces no tick; it needs a fresh debounced 1->0.
// STRUCTURE
//   Shared package game_pkg holds:
//          DEBOUNCE_DEFAULT = 250000
//          TICK_W_DEFAULT = 16
//          typedef mode_e {MODE_AUTO, MODE_MANUAL}
//   Sub-module key_debouncer (2-FF sync + stable counter + press-pulse output), parameterized
//          by DEBOUNCE_CYCLES/CNT_W. Reusable for the other KEY inputs.
//   Remaining logic stays in this module: frame edge, divider, mode FSM, tick counter.
// TESTING
//   1 Reset: rst=1 for 3 cycles with key=0 and sw=1 -> tick_out=0, tick_count_out=0,
//     manual_mode_out=0. After release, manual_mode_out=1 within 3 cycles and no tick.
//   2 Auto, FRAME_DIV=1: 5 frame_sync pulses (high 10, period 100) -> 5 single-cycle ticks,
//     each exactly 1 cycle after its rising edge; tick_count_out=5.
//   3 Auto, FRAME_DIV=3: 7 frame edges -> ticks after edges 3 and 6 only; tick_count_out=2.
//   4 Manual, DEBOUNCE_CYCLES=8: key toggles every 3 cycles x4, then held low 30 cycles ->
//     exactly 1 tick, 2+8+1 cycles after the last toggle. Bouncy release then -> no tick.
//   5 Mode isolation: sw=1 with frame edges continuing -> 0 ticks. sw=0 and a clean key press
//     -> 0 ticks. Switch back to auto mid-frame -> first tick on the next edge, with the
//     divider restarted.
//   6 Wrap/reset, TICK_W=4: 17 auto ticks -> tick_count_out=1. Assert rst mid-debounce with
//     key held low -> no tick after rst deasserts until a release and a new press.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game-step tick path: defaults and the mode encoding.
package game_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 250000;
  localparam int unsigned TICK_W_DEFAULT   = 16;
  localparam int unsigned DIV_W            = 4;

  typedef enum logic {
    MODE_AUTO,
    MODE_MANUAL
  } mode_e;

endpackage

// File: rtl/game_tick_gen_if.sv
// Board-side signals of the game-step generator: switch, key, frame sync in; tick, count, mode out.
interface game_tick_gen_if #(
  parameter int unsigned TICK_W = 16
);

  logic              sw_mode_in;
  logic              key_step_n_in;
  logic              frame_sync_in;
  logic              tick_out;
  logic [TICK_W-1:0] tick_count_out;
  logic              manual_mode_out;

  modport master (
    output sw_mode_in,
    output key_step_n_in,
    output frame_sync_in,
    input  tick_out,
    input  tick_count_out,
    input  manual_mode_out
  );

  modport slave (
    input  sw_mode_in,
    input  key_step_n_in,
    input  frame_sync_in,
    output tick_out,
    output tick_count_out,
    output manual_mode_out
  );

endinterface

// File: rtl/game_tick_gen_key_debouncer.sv
// Active-low push-button conditioner: 2-FF synchronizer, stable-level counter, one-cycle press pulse.
module key_debouncer
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_in,
  output logic press_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_s1;
  logic             key_s2;
  logic             key_db;
  logic [1:0]       warm;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1    <= 1'b1;
      key_s2    <= 1'b1;
      key_db    <= 1'b1;
      warm      <= '0;
      armed     <= 1'b0;
      cnt       <= '0;
      press_out <= 1'b0;
    end else begin
      key_s1    <= key_n_in;
      key_s2    <= key_s1;
      warm      <= {warm[0], 1'b1};
      press_out <= 1'b0;
      // A key held low through reset must be seen released (past the reset-filled
      // synchronizer) before any press counts.
      if (warm[1] && key_s2) begin
        armed <= 1'b1;
      end
      if (key_s2 == key_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        key_db    <= key_s2;
        cnt       <= '0;
        press_out <= armed && !key_s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_tick_gen.sv
// Game-step enable generator: frame-sync driven ticks in auto mode, debounced key presses in manual.
module game_tick_gen
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = 18,
  parameter int unsigned FRAME_DIV       = 1,
  parameter int unsigned TICK_W          = TICK_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  game_tick_gen_if.slave bus
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  logic              sw_s1;
  logic              sw_s2;
  logic              frame_dly;
  logic              frame_edge;
  logic              press;
  mode_e             state;
  logic [DIV_W-1:0]  div;
  logic              tick;
  logic [TICK_W-1:0] tick_count;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_key (
    .clk       (clk),
    .rst       (rst),
    .key_n_in  (bus.key_step_n_in),
    .press_out (press)
  );

  assign frame_edge = bus.frame_sync_in & ~frame_dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1      <= 1'b0;
      sw_s2      <= 1'b0;
      frame_dly  <= 1'b0;
      state      <= MODE_AUTO;
      div        <= '0;
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      sw_s1     <= bus.sw_mode_in;
      sw_s2     <= sw_s1;
      frame_dly <= bus.frame_sync_in;
      tick      <= 1'b0;
      case (state)
        MODE_AUTO: begin
          if (sw_s2) begin
            state <= MODE_MANUAL;
            div   <= '0;
          end else if (frame_edge) begin
            if (div == DIV_LAST) begin
              div        <= '0;
              tick       <= 1'b1;
              tick_count <= tick_count + TICK_W'(1);
            end else begin
              div <= div + DIV_W'(1);
            end
          end
        end
        MODE_MANUAL: begin
          div <= '0;
          if (!sw_s2) begin
            state <= MODE_AUTO;
          end else if (press) begin
            tick       <= 1'b1;
            tick_count <= tick_count + TICK_W'(1);
          end
        end
        default: begin
          state <= MODE_AUTO;
          div   <= '0;
        end
      endcase
    end
  end

  assign bus.tick_out        = tick;
  assign bus.tick_count_out  = tick_count;
  assign bus.manual_mode_out = (state == MODE_MANUAL);

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed bench: three game_tick_gen instances (FRAME_DIV 1/3, TICK_W 16/4) on shared stimulus.
module tb_game_tick_gen;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic sw    = 1'b1;
  logic key_n = 1'b0;
  logic frame = 1'b0;

  always #20 clk = ~clk;

  game_tick_gen_if #(.TICK_W(16)) if_a ();
  game_tick_gen_if #(.TICK_W(16)) if_b ();
  game_tick_gen_if #(.TICK_W(4))  if_c ();

  assign if_a.sw_mode_in    = sw;
  assign if_a.key_step_n_in = key_n;
  assign if_a.frame_sync_in = frame;
  assign if_b.sw_mode_in    = sw;
  assign if_b.key_step_n_in = key_n;
  assign if_b.frame_sync_in = frame;
  assign if_c.sw_mode_in    = sw;
  assign if_c.key_step_n_in = key_n;
  assign if_c.frame_sync_in = frame;

  game_tick_gen #(.DEBOUNCE_CYCLES(8), .CNT_W(4), .FRAME_DIV(1), .TICK_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave)
  );
  game_tick_gen #(.DEBOUNCE_CYCLES(8), .CNT_W(4), .FRAME_DIV(3), .TICK_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );
  game_tick_gen #(.DEBOUNCE_CYCLES(8), .CNT_W(4), .FRAME_DIV(1), .TICK_W(4)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave)
  );

  int checks     = 0;
  int failures   = 0;
  int ticks_a    = 0;
  int ticks_b    = 0;
  int ticks_c    = 0;
  int wide_ticks = 0;
  logic prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;

  always @(negedge clk) begin
    ticks_a += int'(if_a.tick_out === 1'b1);
    ticks_b += int'(if_b.tick_out === 1'b1);
    ticks_c += int'(if_c.tick_out === 1'b1);
    if ((if_a.tick_out === 1'b1) && prev_a) wide_ticks++;
    if ((if_b.tick_out === 1'b1) && prev_b) wide_ticks++;
    if ((if_c.tick_out === 1'b1) && prev_c) wide_ticks++;
    prev_a = (if_a.tick_out === 1'b1);
    prev_b = (if_b.tick_out === 1'b1);
    prev_c = (if_c.tick_out === 1'b1);
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse(output int ta, output int tb, output int tc);
    frame = 1'b1;
    step(1);
    ta = int'(if_a.tick_out === 1'b1);
    tb = int'(if_b.tick_out === 1'b1);
    tc = int'(if_c.tick_out === 1'b1);
    step(9);
    frame = 1'b0;
    step(90);
  endtask

  task automatic press_key(output int lat);
    key_n = 1'b0;
    lat   = -1;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      if (lat < 0 && if_a.tick_out === 1'b1) lat = k;
    end
  endtask

  initial begin
    int ta, tb, tc, lat, base_a, base_b;
    int expb3 [7] = '{0, 0, 1, 0, 0, 1, 0};
    int expb5 [3] = '{0, 0, 1};

    // Reset with key held low and manual switch on
    step(3);
    chk("rst_tick",   int'(if_a.tick_out), 0);
    chk("rst_count",  int'(if_a.tick_count_out), 0);
    chk("rst_manual", int'(if_a.manual_mode_out), 0);
    rst = 1'b0;
    step(3);
    chk("rst_manual_after", int'(if_a.manual_mode_out), 1);
    step(20);
    chk("rst_no_tick", ticks_a, 0);
    sw    = 1'b0;
    key_n = 1'b1;
    step(5);
    chk("auto_mode", int'(if_a.manual_mode_out), 0);

    // Auto, FRAME_DIV=1
    for (int i = 0; i < 5; i++) begin
      frame_pulse(ta, tb, tc);
      chk("div1_tick_lat", ta, 1);
    end
    chk("div1_count", int'(if_a.tick_count_out), 5);
    chk("div1_ticks", ticks_a, 5);

    // Auto, FRAME_DIV=3 from a clean divider
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
    for (int i = 0; i < 7; i++) begin
      frame_pulse(ta, tb, tc);
      chk("div3_edge", tb, expb3[i]);
    end
    chk("div3_count", int'(if_b.tick_count_out), 2);
    chk("div1_count7", int'(if_a.tick_count_out), 7);

    // Manual: bouncy press, then held low
    sw = 1'b1;
    step(5);
    chk("manual_mode", int'(if_a.manual_mode_out), 1);
    base_a = ticks_a;
    for (int i = 0; i < 4; i++) begin
      key_n = ~key_n;
      step(3);
    end
    press_key(lat);
    chk("press_latency", lat, 11);
    chk("press_ticks", ticks_a - base_a, 1);
    chk("press_count_b", int'(if_b.tick_count_out), 3);
    base_a = ticks_a;
    for (int i = 0; i < 4; i++) begin
      key_n = ~key_n;
      step(3);
    end
    key_n = 1'b1;
    step(30);
    chk("release_no_tick", ticks_a - base_a, 0);

    // Mode isolation
    base_a = ticks_a;
    base_b = ticks_b;
    for (int i = 0; i < 3; i++) frame_pulse(ta, tb, tc);
    chk("manual_frames_a", ticks_a - base_a, 0);
    chk("manual_frames_b", ticks_b - base_b, 0);
    sw = 1'b0;
    step(5);
    key_n = 1'b0;
    step(20);
    key_n = 1'b1;
    step(20);
    chk("auto_press_ignored", ticks_a - base_a, 0);
    frame_pulse(ta, tb, tc);
    frame_pulse(ta, tb, tc);
    chk("auto_two_frames", ticks_a - base_a, 2);
    sw = 1'b1;
    step(5);
    frame = 1'b1;
    step(5);
    sw = 1'b0;
    step(5);
    frame = 1'b0;
    step(90);
    chk("mid_frame_no_tick", ticks_a - base_a, 2);
    for (int i = 0; i < 3; i++) begin
      frame_pulse(ta, tb, tc);
      chk("resume_a", ta, 1);
      chk("resume_div_b", tb, expb5[i]);
    end
    chk("resume_count_b", int'(if_b.tick_count_out), 4);

    // Counter wrap at TICK_W=4
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
    for (int i = 0; i < 17; i++) frame_pulse(ta, tb, tc);
    chk("wrap_count_c", int'(if_c.tick_count_out), 1);
    chk("wrap_count_a", int'(if_a.tick_count_out), 17);

    // Reset mid-debounce with key held low
    sw = 1'b1;
    step(5);
    key_n = 1'b0;
    step(5);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    base_a = ticks_a;
    step(40);
    chk("held_rst_no_tick", ticks_a - base_a, 0);
    chk("held_rst_manual", int'(if_a.manual_mode_out), 1);
    key_n = 1'b1;
    step(20);
    press_key(lat);
    chk("repress_ticks", ticks_a - base_a, 1);
    chk("repress_latency", lat, 11);
    chk("repress_count", int'(if_a.tick_count_out), 1);

    chk("single_cycle_ticks", wide_ticks, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
